// File: rtl/crono_pkg.sv
// Shared stopwatch constants: time-word width, lap depth and lap-store full policies.
package crono_pkg;
    localparam int TIME_W      = 24;
    localparam int LAP_DEPTH   = 16;
    localparam int POLICY_STOP = 0;
    localparam int POLICY_WRAP = 1;
endpackage

// File: rtl/lap_ptr_ctrl.sv
// Lap store bookkeeping: write/oldest pointers, lap count, full and sticky overflow.
module lap_ptr_ctrl
    import crono_pkg::*;
#(
    parameter int DEPTH  = LAP_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WRAP   = POLICY_STOP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              capture,
    output logic              we,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] old_ptr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    // Compare-to-last rather than masking so non-power-of-two depths wrap correctly.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] old_ptr_q, old_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        old_ptr_d  = old_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        we         = 1'b0;
        if (reset || clear) begin
            wr_ptr_d   = '0;
            old_ptr_d  = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (capture) begin
            if (!full_q) begin
                we       = 1'b1;
                wr_ptr_d = ptr_inc(wr_ptr_q);
                count_d  = count_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
                if (WRAP == POLICY_WRAP) begin
                    we        = 1'b1;
                    wr_ptr_d  = ptr_inc(wr_ptr_q);
                    old_ptr_d = ptr_inc(old_ptr_q);
                end
            end
        end
        full_d = (count_d == DEPTH_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            old_ptr_q  <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            old_ptr_q  <= old_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_ptr   = wr_ptr_q;
    assign old_ptr  = old_ptr_q;
    assign count    = count_q;
    assign full     = full_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/lap_memory.sv
// Circular lap store: captures time words and reads them back by logical index (0 = oldest).
module lap_memory
    import crono_pkg::*;
#(
    parameter int DATA_W = TIME_W,
    parameter int DEPTH  = LAP_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WRAP   = POLICY_STOP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              capture,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] old_ptr;

    lap_ptr_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WRAP   (WRAP)
    ) u_ptr (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .capture  (capture),
        .we       (we),
        .wr_ptr   (wr_ptr),
        .old_ptr  (old_ptr),
        .count    (count),
        .full     (full),
        .overflow (overflow)
    );

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= data_in;
        end
    end

    logic              rd_hit;
    logic [ADDR_W:0]   rd_sum;
    logic [ADDR_W-1:0] rd_phys;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;

    // Reads use pre-capture state, so a slot overwritten this cycle returns its old word.
    always_comb begin
        rd_hit  = ({1'b0, rd_addr} < count);
        rd_sum  = {1'b0, old_ptr} + {1'b0, rd_addr};
        rd_phys = (rd_sum >= DEPTH_CNT) ? ADDR_W'(rd_sum - DEPTH_CNT) : rd_sum[ADDR_W-1:0];
        if (!rd_hit) begin
            rd_phys = '0;
        end
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        if (rd_en) begin
            data_out_d = '0;
            if (!clear && rd_hit) begin
                data_out_d = mem[rd_phys];
                rd_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_lap_memory.sv
// Bench for lap_memory: three configurations driven in lockstep against a logical lap-list model.
module tb_lap_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        capture = 1'b0;
    logic [23:0] data_in = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;

    logic [23:0] dout [3];
    logic        vld  [3];
    logic        ful  [3];
    logic        ovf  [3];
    logic [4:0]  cnt0, cnt1;
    logic [3:0]  cnt2;

    int compared = 0;
    int mismatched = 0;

    // Model: each instance keeps its laps as a plain list, oldest first.
    int          dep [3] = '{16, 16, 5};
    bit          wrp [3] = '{1'b0, 1'b1, 1'b1};
    logic [23:0] lap [3][16];
    int          mcnt [3];
    bit          movf [3];
    logic [23:0] edout [3];
    bit          evld [3];

    always #5 clk = ~clk;

    lap_memory #(.DATA_W(24), .DEPTH(16), .WRAP(0)) dut0 (
        .clk(clk), .reset(reset), .clear(clear), .capture(capture), .data_in(data_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout[0]), .rd_valid(vld[0]),
        .count(cnt0), .full(ful[0]), .overflow(ovf[0]));

    lap_memory #(.DATA_W(24), .DEPTH(16), .WRAP(1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .capture(capture), .data_in(data_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout[1]), .rd_valid(vld[1]),
        .count(cnt1), .full(ful[1]), .overflow(ovf[1]));

    lap_memory #(.DATA_W(24), .DEPTH(5), .WRAP(1)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .capture(capture), .data_in(data_in),
        .rd_en(rd_en), .rd_addr(rd_addr[2:0]), .data_out(dout[2]), .rd_valid(vld[2]),
        .count(cnt2), .full(ful[2]), .overflow(ovf[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst_i, input bit clr_i, input bit cap_i, input logic [23:0] d_i,
                        input bit rde_i, input logic [3:0] a_i);
        int ai;
        logic [31:0] obs_cnt;
        reset   = rst_i;
        clear   = clr_i;
        capture = cap_i;
        data_in = d_i;
        rd_en   = rde_i;
        rd_addr = a_i;
        for (int i = 0; i < 3; i++) begin
            ai = (i == 2) ? int'(a_i[2:0]) : int'(a_i);
            if (rst_i) begin
                evld[i] = 1'b0; edout[i] = '0;
            end else if (rde_i) begin
                if (!clr_i && ai < mcnt[i]) begin
                    evld[i] = 1'b1; edout[i] = lap[i][ai];
                end else begin
                    evld[i] = 1'b0; edout[i] = '0;
                end
            end else begin
                evld[i] = 1'b0;
            end
            if (rst_i || clr_i) begin
                mcnt[i] = 0; movf[i] = 1'b0;
            end else if (cap_i) begin
                if (mcnt[i] < dep[i]) begin
                    lap[i][mcnt[i]] = d_i;
                    mcnt[i]++;
                end else begin
                    movf[i] = 1'b1;
                    if (wrp[i]) begin
                        for (int k = 0; k < dep[i] - 1; k++) lap[i][k] = lap[i][k+1];
                        lap[i][dep[i]-1] = d_i;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            obs_cnt = (i == 0) ? 32'(cnt0) : (i == 1) ? 32'(cnt1) : 32'(cnt2);
            chk($sformatf("count[%0d]", i), obs_cnt, 32'(mcnt[i]));
            chk($sformatf("full[%0d]", i), 32'(ful[i]), 32'(mcnt[i] == dep[i]));
            chk($sformatf("overflow[%0d]", i), 32'(ovf[i]), 32'(movf[i]));
            chk($sformatf("rd_valid[%0d]", i), 32'(vld[i]), 32'(evld[i]));
            chk($sformatf("data_out[%0d]", i), 32'(dout[i]), 32'(edout[i]));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mcnt[i] = 0; movf[i] = 1'b0; edout[i] = '0; evld[i] = 1'b0;
        end
        // Reset state
        step(1, 0, 0, 24'h0, 0, 4'd0);
        step(1, 0, 1, 24'h123, 1, 4'd0);
        step(0, 0, 0, 24'h0, 0, 4'd0);

        // Three laps and read-back
        step(0, 0, 1, 24'h000105, 0, 4'd0);
        step(0, 0, 1, 24'h000210, 0, 4'd0);
        step(0, 0, 1, 24'h000315, 0, 4'd0);
        for (int a = 0; a < 3; a++) step(0, 0, 0, 24'h0, 1, 4'(a));
        chk("plan1_idx2", 32'(dout[0]), 32'h000315);
        step(0, 0, 0, 24'h0, 0, 4'd0);

        // Out-of-range reads
        step(0, 1, 0, 24'h0, 0, 4'd0);
        step(0, 0, 1, 24'h0000AA, 0, 4'd0);
        step(0, 0, 1, 24'h0000BB, 0, 4'd0);
        step(0, 0, 0, 24'h0, 1, 4'd5);
        step(0, 0, 1, 24'h0000CC, 1, 4'd2);
        step(0, 0, 0, 24'h0, 1, 4'd2);

        // clear beats capture
        step(0, 0, 1, 24'h0000DD, 0, 4'd0);
        step(0, 1, 1, 24'h0000EE, 0, 4'd0);
        step(0, 0, 0, 24'h0, 1, 4'd0);
        step(0, 1, 0, 24'h0, 1, 4'd0);

        // Fill past capacity with 1..17, then 1..18, then 10..16
        for (int v = 1; v <= 17; v++) step(0, 0, 1, 24'(v), 0, 4'd0);
        step(0, 0, 0, 24'h0, 1, 4'd0);
        chk("stop_idx0", 32'(dout[0]), 32'd1);
        step(0, 0, 0, 24'h0, 1, 4'd15);
        chk("stop_idx15", 32'(dout[0]), 32'd16);
        step(0, 1, 0, 24'h0, 0, 4'd0);
        for (int v = 1; v <= 18; v++) step(0, 0, 1, 24'(v), 0, 4'd0);
        step(0, 0, 0, 24'h0, 1, 4'd0);
        chk("wrap_idx0", 32'(dout[1]), 32'd3);
        step(0, 0, 0, 24'h0, 1, 4'd15);
        chk("wrap_idx15", 32'(dout[1]), 32'd18);
        step(0, 1, 0, 24'h0, 0, 4'd0);
        for (int v = 10; v <= 16; v++) step(0, 0, 1, 24'(v), 0, 4'd0);
        for (int a = 0; a < 5; a++) begin
            step(0, 0, 0, 24'h0, 1, 4'(a));
            chk($sformatf("d5_idx%0d", a), 32'(dout[2]), 32'(12 + a));
        end

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) < 6), 24'($urandom), ($urandom_range(0, 9) < 6),
                 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
